trdb_packet_streamer: RTL and testbench



---
 rtl/trdb_packet_streamer.sv | 180 ++++++++++++++++++
 tb/tb_trdb_packet_streamer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trdb_packet_streamer.sv
// trdb_packet_streamer: buffers whole trace packets, frames each with a
// {seq,len} header byte and serialises it onto a narrow valid/ready beat bus.
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   valid_i/ready_o        packet input handshake (ready_o = FIFO not full)
//   payload_i              packet bytes, byte 0 in bits [7:0]
//   payload_length_i       payload byte count minus one
//   data_o/be_o            beat data and byte enables, lane 0 in bits [7:0]
//   valid_o/ready_i/last_o beat handshake, last_o marks final beat
//   drop_cnt_o             saturating count of packets dropped on full
//   seq_o                  sequence number of the next accepted packet
module trdb_packet_streamer #(
  parameter int unsigned PAYLOAD_W = 256,
  parameter int unsigned OUT_W     = 32,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  input  logic [PAYLOAD_W-1:0] payload_i,
  input  logic [4:0]           payload_length_i,
  output logic                 ready_o,
  output logic [OUT_W-1:0]     data_o,
  output logic [OUT_W/8-1:0]   be_o,
  output logic                 valid_o,
  output logic                 last_o,
  input  logic                 ready_i,
  output logic [15:0]          drop_cnt_o,
  output logic [2:0]           seq_o
);

  localparam int unsigned BPB    = OUT_W / 8;
  localparam int unsigned NB_MAX = PAYLOAD_W / 8 + 1;
  localparam int unsigned BEATS  = (NB_MAX + BPB - 1) / BPB;
  localparam int unsigned IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned FRM_W  = BEATS * OUT_W;
  localparam int unsigned PTR_W  = $clog2(DEPTH);

  localparam logic [PTR_W:0] PTR_ONE = 1;
  localparam logic [IDX_W-1:0] IDX_ONE = 1;

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  state_e state_q, state_d;

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_w;
  logic [2:0]       seq_q;
  logic [15:0]      drop_q;

  logic [PAYLOAD_W-1:0] pay_q [DEPTH];
  logic [4:0]           len_q [DEPTH];
  logic [2:0]           sq_q  [DEPTH];

  logic full, empty;
  logic push, drop, pop;
  logic fire, is_last;

  logic [PAYLOAD_W-1:0] head_pay;
  logic [4:0]           head_len;
  logic [2:0]           head_seq;
  logic [7:0]           hdr;
  logic [FRM_W-1:0]     framed;

  assign count_w = wr_ptr_q - rd_ptr_q;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  // Same slot index with differing wrap bits means full.
  assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  assign ready_o    = !full;
  assign push       = valid_i && !full;
  assign drop       = valid_i && full;
  assign seq_o      = seq_q;
  assign drop_cnt_o = drop_q;

  assign head_pay = pay_q[rd_ptr_q[PTR_W-1:0]];
  assign head_len = len_q[rd_ptr_q[PTR_W-1:0]];
  assign head_seq = sq_q[rd_ptr_q[PTR_W-1:0]];
  assign hdr      = {head_seq, head_len};
  assign framed   = FRM_W'({head_pay, hdr});

  assign fire    = valid_o && ready_i;
  // Last stream byte index is len+1; its beat is the final one.
  assign is_last = (int'(idx_q) ==
                    (int'(head_len) + 1) / int'(BPB));

  // Packet storage carries no reset; validity lives in the pointers.
  always_ff @(posedge clk_i) begin
    if (push) begin
      pay_q[wr_ptr_q[PTR_W-1:0]] <= payload_i;
      len_q[wr_ptr_q[PTR_W-1:0]] <= payload_length_i;
      sq_q[wr_ptr_q[PTR_W-1:0]]  <= seq_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      seq_q    <= '0;
      drop_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
        seq_q    <= seq_q + 3'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      if (drop && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'd1;
      end
    end
  end

  // Entering SEND on a push lets the first beat show one cycle
  // after acceptance even though valid_o comes from state.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty || push) begin
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        if (fire) begin
          if (is_last) begin
            pop   = 1'b1;
            idx_d = '0;
            if ((|count_w[PTR_W:1]) || push) begin
              state_d = SEND;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Beat is built from the head and index, both frozen while stalled,
  // so the hold rule falls out without an output register.
  always_comb begin
    valid_o = 1'b0;
    last_o  = 1'b0;
    data_o  = '0;
    be_o    = '0;
    if (state_q == SEND) begin
      valid_o = 1'b1;
      last_o  = is_last;
      for (int j = 0; j < int'(BPB); j++) begin
        if (int'(idx_q) * int'(BPB) + j <= int'(head_len) + 1) begin
          data_o[j*8 +: 8] =
            framed[(int'(idx_q) * int'(BPB) + j) * 8 +: 8];
          be_o[j] = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_trdb_packet_streamer.sv
// tb_trdb_packet_streamer: directed bench for trdb_packet_streamer
// with hand-derived beats, byte enables, sequence and drop counts.
module tb_trdb_packet_streamer;

  localparam int PW = 256;
  localparam int OW = 32;
  localparam int D  = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          valid_i = 1'b0;
  logic [PW-1:0] payload_i = '0;
  logic [4:0]    payload_length_i = '0;
  logic          ready_o;
  logic [OW-1:0] data_o;
  logic [OW/8-1:0] be_o;
  logic          valid_o;
  logic          last_o;
  logic          ready_i = 1'b0;
  logic [15:0]   drop_cnt_o;
  logic [2:0]    seq_o;

  int errs = 0;
  int checks = 0;

  int hs, cyc, stale, p, b;
  logic [31:0] ed;
  logic [3:0]  eb;
  logic [7:0]  eh, bb;
  logic [31:0] bp_d [3];
  logic [3:0]  bp_b [3];
  logic        rdy_pat [4];

  trdb_packet_streamer #(
    .PAYLOAD_W(PW),
    .OUT_W(OW),
    .DEPTH(D)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .valid_i(valid_i),
    .payload_i(payload_i),
    .payload_length_i(payload_length_i),
    .ready_o(ready_o),
    .data_o(data_o),
    .be_o(be_o),
    .valid_o(valid_o),
    .last_o(last_o),
    .ready_i(ready_i),
    .drop_cnt_o(drop_cnt_o),
    .seq_o(seq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [PW-1:0] mkpay(input logic [7:0] base);
    logic [PW-1:0] v;
    v = '0;
    for (int i = 0; i < PW/8; i++) v[i*8 +: 8] = base + 8'(i);
    return v;
  endfunction

  initial begin
    bp_d = '{32'hA2A1A047, 32'hA6A5A4A3, 32'h000000A7};
    bp_b = '{4'hF, 4'hF, 4'h1};
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    // reset state
    repeat (2) tick();
    chk("rst_ready", ready_o, 1);
    chk("rst_valid", valid_o, 0);
    chk("rst_last", last_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_be", be_o, 0);
    chk("rst_drop", drop_cnt_o, 0);
    chk("rst_seq", seq_o, 0);
    rst_ni = 1'b1;
    tick();

    // single byte packet
    payload_i = '0;
    payload_i[7:0] = 8'hAB;
    payload_length_i = 5'd0;
    valid_i = 1'b1;
    ready_i = 1'b1;
    tick();
    valid_i = 1'b0;
    chk("sb_valid", valid_o, 1);
    chk("sb_data", data_o, 32'h0000AB00);
    chk("sb_be", be_o, 4'b0011);
    chk("sb_last", last_o, 1);
    chk("sb_seq", seq_o, 1);
    tick();
    chk("sb_idle", valid_o, 0);

    // max packet, seq 1
    payload_i = mkpay(8'h00);
    payload_length_i = 5'd31;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    chk("max_seq", seq_o, 2);
    for (int k = 0; k < 9; k++) begin
      if (k == 0) ed = 32'h0201003F;
      else if (k == 8) ed = 32'h0000001F;
      else ed = {8'(4*k+2), 8'(4*k+1), 8'(4*k), 8'(4*k-1)};
      eb = (k == 8) ? 4'b0001 : 4'b1111;
      chk($sformatf("max_v%0d", k), valid_o, 1);
      chk($sformatf("max_d%0d", k), data_o, ed);
      chk($sformatf("max_be%0d", k), be_o, eb);
      chk($sformatf("max_l%0d", k), last_o, k == 8);
      tick();
    end
    chk("max_idle", valid_o, 0);

    // backpressure on len=7, seq 2 -> header 0x47
    payload_i = mkpay(8'hA0);
    payload_length_i = 5'd7;
    valid_i = 1'b1;
    ready_i = 1'b0;
    tick();
    valid_i = 1'b0;
    hs = 0;
    cyc = 0;
    while (valid_o && cyc < 20 && hs < 3) begin
      ready_i = (cyc < 4) ? rdy_pat[cyc] : 1'b1;
      chk($sformatf("bp_d%0d", cyc), data_o, bp_d[hs]);
      chk($sformatf("bp_be%0d", cyc), be_o, bp_b[hs]);
      chk($sformatf("bp_l%0d", cyc), last_o, hs == 2);
      if (ready_i) hs++;
      cyc++;
      tick();
    end
    chk("bp_hs", hs, 3);
    chk("bp_cyc", cyc, 5);
    chk("bp_idle", valid_o, 0);

    // overflow from fresh reset
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    ready_i = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      payload_i = '0;
      payload_i[7:0] = 8'h10 + 8'(i);
      payload_length_i = 5'd0;
      valid_i = 1'b1;
      chk($sformatf("ovf_rdy%0d", i), ready_o, i < 4);
      tick();
    end
    valid_i = 1'b0;
    chk("ovf_drop", drop_cnt_o, 2);
    chk("ovf_seq", seq_o, 4);
    chk("ovf_full", ready_o, 0);
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ed = {16'h0, 8'h10 + 8'(i), 3'(i), 5'd0};
      chk($sformatf("ovf_v%0d", i), valid_o, 1);
      chk($sformatf("ovf_d%0d", i), data_o, ed);
      chk($sformatf("ovf_l%0d", i), last_o, 1);
      tick();
    end
    chk("ovf_idle", valid_o, 0);
    chk("ovf_rdy", ready_o, 1);

    // back-to-back: 3 packets len=4, seq 4,5,6
    for (int c = 0; c < 7; c++) begin
      if (c < 3) begin
        valid_i = 1'b1;
        payload_i = mkpay(8'h30 + 8'(16*c));
        payload_length_i = 5'd4;
      end else begin
        valid_i = 1'b0;
      end
      tick();
      if (c < 6) begin
        p = c / 2;
        b = c % 2;
        bb = 8'h30 + 8'(16*p);
        eh = {3'(4+p), 5'd4};
        if (b == 0) ed = {bb + 8'd2, bb + 8'd1, bb, eh};
        else ed = {16'h0, bb + 8'd4, bb + 8'd3};
        chk($sformatf("b2b_v%0d", c), valid_o, 1);
        chk($sformatf("b2b_l%0d", c), last_o, b == 1);
        chk($sformatf("b2b_d%0d", c), data_o, ed);
        chk($sformatf("b2b_be%0d", c), be_o,
            (b == 1) ? 4'b0011 : 4'b1111);
      end else begin
        chk("b2b_idle", valid_o, 0);
      end
    end

    // reset during beat 2 with two packets queued behind
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      payload_i = mkpay(8'h00);
      payload_length_i = 5'd31;
      valid_i = 1'b1;
      tick();
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    tick();
    tick();
    chk("mr_pre_d", data_o, 32'h0A090807);
    chk("mr_pre_drop", drop_cnt_o, 2);
    rst_ni = 1'b0;
    #1;
    chk("mr_valid", valid_o, 0);
    chk("mr_ready", ready_o, 1);
    chk("mr_seq", seq_o, 0);
    chk("mr_drop", drop_cnt_o, 0);
    chk("mr_data", data_o, 0);
    chk("mr_be", be_o, 0);
    chk("mr_last", last_o, 0);
    tick();
    rst_ni = 1'b1;
    stale = 0;
    repeat (6) begin
      tick();
      if (valid_o) stale++;
    end
    chk("mr_stale", stale, 0);
    chk("mr_post_rdy", ready_o, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
